pa_wb_arbiter: RTL
==================

// Module: pa_wb_arbiter
// PURPOSE
//   Shares PA_Core's single register-file writeback port A among NUM_REQ execution units
//   (arith, load/store, link).
//   Round-robin grant of at most one request per cycle over a valid/ready handshake.
//   The winner is registered onto wbAFinal_o / wbAddrAFinal_o / wbValAFinal_o with 1-cycle latency.
//   Sits between the execute-stage units and the register file.
// PARAMETERS
//   NUM_REQ  3   number of requesting units (2..8)
//   ADDR_W   5   register address width
//   DATA_W   16  writeback data width
// PORTS
//   clock_i         in   1               single clock, rising edge
//   reset_i         in   1               asynchronous, active-low reset
//   req_valid_i     in   NUM_REQ         per-unit writeback request
//   req_addr_i      in   NUM_REQ*ADDR_W  packed dest addresses; unit k at [k*ADDR_W +: ADDR_W]
//   req_val_i       in   NUM_REQ*DATA_W  packed writeback values; unit k at [k*DATA_W +: DATA_W]
//   req_ready_o     out  NUM_REQ         one-hot grant; transfer when valid&ready
//   wbAFinal_o      out  1               regfile write enable (1-cycle pulse per write)
//   wbAddrAFinal_o  out  ADDR_W          regfile write address
//   wbValAFinal_o   out  DATA_W          regfile write data
//   stat_grants_o   out  NUM_REQ*16      per-unit grant counts; present only with PA_WB_STATS_EN
//   stat_conflict_o out  16              conflict-cycle count; present only with PA_WB_STATS_EN
// BEHAVIOUR
//   - Reset (reset_i=0, async assert):
//     - wbAFinal_o=0, wbAddrAFinal_o=0, wbValAFinal_o=0, req_ready_o=0.
//     - RR pointer=0; stats=0.
//     - Deassertion is sampled synchronously on clock_i.
//   - Requester rule: once req_valid_i[k]=1, addr/val stay stable until req_ready_o[k]=1 that cycle.
//   - Grant is combinational from current valids and the RR pointer:
//     - first valid unit scanning k = ptr, ptr+1, ... mod NUM_REQ.
//     - req_ready_o = one-hot of that unit, or 0 if none valid.
//     - req_ready_o never asserts for a unit with valid=0.
//   - On a grant to unit g at edge t:
//     - at t+1: wbAFinal_o=1, wbAddrAFinal_o=addr[g], wbValAFinal_o=val[g].
//     - ptr <= (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
//   - No grant: wbAFinal_o=0; addr/val hold their previous values; ptr unchanged.
//   - Throughput: one write per cycle; no backpressure from the regfile.
//   - Fairness: a continuously valid unit is granted within NUM_REQ cycles.
//   - Ordering:
//     - same-address requests from different units are NOT reordered within the arbiter.
//     - older-first ordering is the issue logic's responsibility.
//   - Reset mid-operation: an in-flight output write is dropped (wbAFinal_o forced 0); no replay.
// CONFIGURATION
//   - `PA_WB_STATS_EN defined:
//     - stat_grants_o[k] increments on each grant to unit k.
//     - stat_conflict_o increments on each cycle with >=2 valids.
//     - 16-bit counters, saturating at 16'hFFFF.
//   - Undefined: stat ports and counters absent; arbitration identical, cycle for cycle.
// STRUCTURE
//   - Package pa_wb_pkg:
//     - ADDR_W=5, DATA_W=16.
//     - typedef wb_req_t {valid, addr[ADDR_W-1:0], val[DATA_W-1:0]}.
//     - STAT_W=16.
//   - Sub-module pa_rr_picker (combinational):
//     - inputs: req vector, ptr.
//     - outputs: one-hot grant, grant index, any-grant flag.
//   - Top module holds the ptr register, output registers and optional stat counters.
// TESTING
//   1. Reset: hold reset_i=0 with all valids=1 -> all outputs 0, req_ready_o=0.
//      Release reset -> first grant goes to unit 0.
//   2. Single unit: unit1 valid, addr=5'd7, val=16'hBEEF.
//      -> req_ready_o=3'b010 same cycle.
//      -> next cycle wbAFinal_o=1, wbAddrAFinal_o=7, wbValAFinal_o=16'hBEEF; then wbAFinal_o=0.
//   3. Round-robin: all 3 valid and held for 6 cycles -> grant order 0,1,2,0,1,2.
//      Output addrs/vals match each unit in that order; pointer wraps 2 -> 0.
//   4. Pointer skip: ptr=1, only units 0 and 2 valid -> grant 2, then 0 (unit 1 idle skipped).
//   5. Async reset mid-burst: assert reset_i between edges while wbAFinal_o=1.
//      -> wbAFinal_o=0 immediately; after release, grant restarts at unit 0.
//   6. PA_WB_STATS_EN: 10 cycles with units 0 and 2 both valid.
//      -> stat_grants = {0:5, 1:0, 2:5}, stat_conflict_o=10.
//      Preload near saturation -> counter holds at 16'hFFFF.

Source files
------------

// File: rtl/pa_wb_pkg.sv
// ============================================================================
// Module   : pa_wb_pkg
// Purpose  : Shared types, widths and helpers for the writeback-port arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pa_wb_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 16;
   localparam int STAT_W = 16;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] val;
   } wb_req_t;

   // A one-requester arbiter still needs a 1-bit index.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pa_rr_picker.sv
// ============================================================================
// Module   : pa_rr_picker
// Purpose  : Combinational round-robin pick: first set request at or after ptr.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pa_rr_picker #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = pa_wb_pkg::idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   always_comb begin
      int k;
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
         k = (int'(i_ptr) + off) % NUM_REQ;
         if (!o_any && i_req[IDX_W'(k)]) begin
            o_any             = 1'b1;
            o_idx             = IDX_W'(k);
            o_gnt[IDX_W'(k)]  = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/pa_wb_arbiter.sv
// ============================================================================
// Module   : pa_wb_arbiter
// Purpose  : Round-robin arbiter sharing register-file writeback port A.
//            Optional statistics counters enabled by macro PA_WB_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pa_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = pa_wb_pkg::ADDR_W,
   parameter int DATA_W  = pa_wb_pkg::DATA_W
) (
   input  logic                        clock_i,
   input  logic                        reset_i,
   input  logic [NUM_REQ-1:0]          req_valid_i,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0]   req_val_i,
   output logic [NUM_REQ-1:0]          req_ready_o,
   output logic                        wbAFinal_o,
   output logic [ADDR_W-1:0]           wbAddrAFinal_o,
   output logic [DATA_W-1:0]           wbValAFinal_o
`ifdef PA_WB_STATS_EN
  ,output logic [NUM_REQ*pa_wb_pkg::STAT_W-1:0] stat_grants_o,
   output logic [pa_wb_pkg::STAT_W-1:0]         stat_conflict_o
`endif
);

   import pa_wb_pkg::*;

   localparam int IDX_W = idx_w(NUM_REQ);

   logic [IDX_W-1:0]   r_ptr;
   logic [NUM_REQ-1:0] w_gnt;
   logic [IDX_W-1:0]   w_idx;
   logic               w_any;
   logic               r_wb_en;
   logic [ADDR_W-1:0]  r_wb_addr;
   logic [DATA_W-1:0]  r_wb_val;

   pa_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .i_req   (req_valid_i),
      .i_ptr   (r_ptr),
      .o_gnt   (w_gnt),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // Ready is masked while reset is held so no unit sees a transfer that is then lost.
   assign req_ready_o = w_gnt & {NUM_REQ{reset_i}};

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         r_ptr     <= '0;
         r_wb_en   <= 1'b0;
         r_wb_addr <= '0;
         r_wb_val  <= '0;
      end else begin
         r_wb_en <= w_any;
         if (w_any) begin
            r_wb_addr <= req_addr_i[w_idx*ADDR_W +: ADDR_W];
            r_wb_val  <= req_val_i[w_idx*DATA_W +: DATA_W];
            r_ptr     <= (w_idx == IDX_W'(NUM_REQ-1)) ? '0 : w_idx + IDX_W'(1);
         end
      end
   end

   assign wbAFinal_o     = r_wb_en;
   assign wbAddrAFinal_o = r_wb_addr;
   assign wbValAFinal_o  = r_wb_val;

`ifdef PA_WB_STATS_EN
   logic [STAT_W-1:0] r_gcnt [NUM_REQ];
   logic [STAT_W-1:0] r_conflict;
   logic              w_conflict;

   assign w_conflict = ($countones(req_valid_i) > 1);

   generate
      for (genvar k = 0; k < NUM_REQ; k++) begin : g_stat
         always_ff @(posedge clock_i or negedge reset_i) begin
            if (!reset_i)
               r_gcnt[k] <= '0;
            else if (w_gnt[k])
               r_gcnt[k] <= sat_inc(r_gcnt[k]);
         end
         assign stat_grants_o[k*STAT_W +: STAT_W] = r_gcnt[k];
      end
   endgenerate

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i)
         r_conflict <= '0;
      else if (w_conflict)
         r_conflict <= sat_inc(r_conflict);
   end

   assign stat_conflict_o = r_conflict;
`endif

endmodule

`default_nettype wire
